// File: rtl/rr_bus_arbiter4_pkg.sv
// Shared constants and types for the 4-master round-robin bus arbiter.
package rr_bus_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Pointer starts at the last master so master 0 has first priority.
    localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter4_if.sv
// Request/grant/completion bundle between the masters, the arbiter and the slave.
interface rr_bus_arbiter4_if;
    import rr_bus_arbiter4_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               bus_ready;
    logic [SEL_W-1:0]   sel;
    logic [NUM_REQ-1:0] grant;
    logic               bus_valid;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] err;
    logic               busy;

    modport master (
        input  req, bus_ready,
        output sel, grant, bus_valid, done, err, busy
    );

    modport slave (
        output req, bus_ready,
        input  sel, grant, bus_valid, done, err, busy
    );

endinterface

// File: rtl/rr_bus_arbiter4_pick.sv
// Combinational round-robin picker: first requester after the last owner wins.
module rr_pick4
    import rr_bus_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   last_i,
    output logic               any_o,
    output logic [SEL_W-1:0]   winner_o
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last_i + SEL_W'(i);
            if (!any_o && req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Round-robin arbiter and transaction sequencer for one shared 32-bit bus port.
//   state | meaning
//   IDLE  | no owner; done/err pulse cycle; arbitrate pending requests
//   BUSY  | owner granted, bus_valid high, waiting for bus_ready or timeout
module rr_bus_arbiter4
    import rr_bus_arbiter4_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset_n,
    rr_bus_arbiter4_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_winner;

    rr_pick4 u_pick (
        .req_i    (bus.req),
        .last_i   (last_q),
        .any_o    (pick_any),
        .winner_o (pick_winner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            sel_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    grant_d = onehot(pick_winner);
                    sel_d   = pick_winner;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // Ready takes precedence over a timeout in the same cycle.
                if (bus.bus_ready) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    last_d  = sel_q;
                    state_d = IDLE;
                end else if (cnt_q == CNT_TC) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    last_d  = sel_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.bus_valid = (state_q == BUSY);
    assign bus.busy      = (state_q == BUSY);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_rr_bus_arbiter4;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic clk;
    logic reset_n;

    rr_bus_arbiter4_if bus_if ();

    rr_bus_arbiter4 #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: owner index (-1 = none), pointer, elapsed busy cycles.
    int m_owner;
    int m_last;
    int m_age;
    int m_sel;
    int m_done;
    int m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_age   = 0;
        m_sel   = 0;
        m_done  = 0;
        m_err   = 0;
    endtask

    task automatic model_clock();
        logic [3:0] r;
        r      = bus_if.req;
        m_done = 0;
        m_err  = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && r[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                    m_sel   = m_owner;
                    m_age   = 1;
                end
            end
        end else if (bus_if.bus_ready) begin
            m_done  = 1 << m_owner;
            m_last  = m_owner;
            m_owner = -1;
        end else if (m_age == TIMEOUT) begin
            m_err   = 1 << m_owner;
            m_last  = m_owner;
            m_owner = -1;
        end else begin
            m_age++;
        end
    endtask

    task automatic check_outputs(input string tag);
        int eg;
        eg = (m_owner < 0) ? 0 : (1 << m_owner);
        chk({tag, "_grant"}, 32'(bus_if.grant),     32'(eg));
        chk({tag, "_sel"},   32'(bus_if.sel),       32'(m_sel));
        chk({tag, "_valid"}, 32'(bus_if.bus_valid), 32'(m_owner >= 0));
        chk({tag, "_busy"},  32'(bus_if.busy),      32'(m_owner >= 0));
        chk({tag, "_done"},  32'(bus_if.done),      32'(m_done));
        chk({tag, "_err"},   32'(bus_if.err),       32'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Called at a negedge; reset asserts and releases between clock edges.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    int n_valid;
    bit seen;
    int pct;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n          = 1'b0;
        bus_if.req       = 4'b0000;
        bus_if.bus_ready = 1'b0;
        model_reset();
        #3;
        check_outputs("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Single request from master 0.
        bus_if.req = 4'b0001;
        step("t1");
        chk("t1_grant", 32'(bus_if.grant), 32'h1);
        chk("t1_valid", 32'(bus_if.bus_valid), 32'h1);
        step("t1");
        step("t1");
        bus_if.bus_ready = 1'b1;
        bus_if.req       = 4'b0000;
        step("t1");
        chk("t1_done", 32'(bus_if.done), 32'h1);
        bus_if.bus_ready = 1'b0;
        step("t1");
        chk("t1_done_clr", 32'(bus_if.done), 32'h0);

        // Round robin with all masters requesting.
        do_reset();
        bus_if.req       = 4'b1111;
        bus_if.bus_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("t2");
            chk("t2_grant", 32'(bus_if.grant), 32'(1 << (i % 4)));
            chk("t2_sel", 32'(bus_if.sel), 32'(i % 4));
            step("t2");
        end
        bus_if.req = 4'b0000;
        step("t2");
        bus_if.bus_ready = 1'b0;
        step("t2");

        // Timeout on master 2, then re-grant in the err cycle.
        do_reset();
        bus_if.req = 4'b0100;
        n_valid    = 0;
        seen       = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step("t3");
            if (bus_if.bus_valid) n_valid++;
            if (bus_if.err != 4'b0000) seen = 1'b1;
        end
        chk("t3_err_seen", 32'(seen), 32'h1);
        chk("t3_valid_len", 32'(n_valid), 32'(TIMEOUT));
        chk("t3_err", 32'(bus_if.err), 32'h4);
        chk("t3_done", 32'(bus_if.done), 32'h0);
        step("t3");
        chk("t3_regrant", 32'(bus_if.grant), 32'h4);

        // Ready in the last allowed busy cycle: done, not err.
        bus_if.bus_ready = 1'b1;
        bus_if.req       = 4'b0000;
        step("t3");
        bus_if.bus_ready = 1'b0;
        step("t3");
        bus_if.req = 4'b0100;
        step("t4");
        for (int c = 0; c < TIMEOUT - 1; c++) step("t4");
        bus_if.bus_ready = 1'b1;
        bus_if.req       = 4'b0000;
        step("t4");
        chk("t4_done", 32'(bus_if.done), 32'h4);
        chk("t4_err", 32'(bus_if.err), 32'h0);
        bus_if.bus_ready = 1'b0;
        step("t4");

        // Reset mid-transaction.
        do_reset();
        bus_if.req = 4'b0010;
        step("t5");
        step("t5");
        chk("t5_busy_pre", 32'(bus_if.busy), 32'h1);
        do_reset();
        chk("t5_rst_done", 32'(bus_if.done), 32'h0);
        chk("t5_rst_err", 32'(bus_if.err), 32'h0);
        bus_if.req = 4'b1010;
        step("t5");
        chk("t5_first_grant", 32'(bus_if.grant), 32'h2);
        bus_if.req       = 4'b0000;
        bus_if.bus_ready = 1'b1;
        step("t5");
        bus_if.bus_ready = 1'b0;
        step("t5");

        // Late request from master 0 during master 3 ownership; pointer wraps.
        do_reset();
        bus_if.req = 4'b1000;
        step("t6");
        bus_if.req = 4'b1001;
        step("t6");
        chk("t6_hold_grant", 32'(bus_if.grant), 32'h8);
        chk("t6_hold_sel", 32'(bus_if.sel), 32'h3);
        bus_if.req       = 4'b0001;
        bus_if.bus_ready = 1'b1;
        step("t6");
        chk("t6_done", 32'(bus_if.done), 32'h8);
        bus_if.bus_ready = 1'b0;
        step("t6");
        chk("t6_wrap_grant", 32'(bus_if.grant), 32'h1);
        bus_if.req       = 4'b0000;
        bus_if.bus_ready = 1'b1;
        step("t6");
        bus_if.bus_ready = 1'b0;
        step("t6");

        // Random traffic with varying slave responsiveness.
        for (int i = 0; i < 1500; i++) begin
            case (i / 300)
                0:       pct = 40;
                1:       pct = 10;
                2:       pct = 3;
                3:       pct = 70;
                default: pct = 20;
            endcase
            if (i == 777) do_reset();
            if ($urandom_range(0, 3) == 0) bus_if.req = 4'($urandom_range(0, 15));
            bus_if.bus_ready = ($urandom_range(0, 99) < pct);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter4.md
Name: rr_bus_arbiter4

Overview:
- Round-robin arbiter and sequencer for one shared 32-bit bus port used by 4 masters.
- The masters are IF, MEM, DMA and debug.
- Drives the 2-bit select of the 4:1 32-bit datapath mux (mux4_32) in front of the port.
- Runs a request/complete handshake with the slave and aborts a transaction on timeout.
- Sits between the master request lines and the shared memory/peripheral bus.

Parameters:
- TIMEOUT, 15: BUSY cycles without bus_ready before the transaction is aborted. Legal range 1..(2^CNT_W - 1).
- CNT_W, 4: width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  4  per-master request level; held high until done/err for that master.
- bus_ready  in  1  slave completion pulse, sampled only in BUSY.
- sel  out  2  select to the 4:1 data/address mux (00=m0 .. 11=m3).
- grant  out  4  one-hot current owner, 0 when idle.
- bus_valid  out  1  transaction presented to slave.
- done  out  4  one-hot, 1-cycle completion pulse to the owner.
- err  out  4  one-hot, 1-cycle timeout pulse to the owner.
- busy  out  1  high in BUSY.

Behaviour:
- Reset values (asynchronous, immediate on reset_n low):
  - outputs: sel=00, grant=0000, bus_valid=0, done=0000, err=0000, busy=0.
  - internal: state=IDLE, last pointer=3 (so master 0 has first priority), cnt=0.
- IDLE state:
  - done and err are zero except for the single pulse cycle after leaving BUSY. bus_valid=0. grant=0. sel holds its last value.
  - If req!=0: winner = first set bit scanning (last+1), (last+2), ... mod 4.
  - Next edge: grant=onehot(winner), sel=winner, bus_valid=1, busy=1, cnt=0, state=BUSY.
  - Arbitration latency is 1 cycle from req seen to grant.
- BUSY state:
  - grant, sel and bus_valid are held stable.
  - req changes are ignored. Dropping req mid-transaction does not abort it.
  - bus_ready=1: next edge done[owner]=1 for one cycle, grant=0, bus_valid=0, busy=0, last=owner, state=IDLE.
  - bus_ready=0 and cnt==TIMEOUT-1: next edge err[owner]=1 for one cycle, grant=0, bus_valid=0, busy=0, last=owner, state=IDLE.
  - Otherwise cnt increments.
  - The abort fires after exactly TIMEOUT BUSY cycles without ready.
- Simultaneous ready and timeout in the same cycle: ready wins. done pulses and err stays 0.
- There is always exactly one IDLE cycle between transactions. This IDLE cycle is the done/err pulse cycle, and re-arbitration occurs in it.
- Maximum throughput is one transaction per 2 cycles.
- bus_ready while in IDLE is ignored.
- done and err are never both set. At most one bit of each is set.
- Fairness: a continuously requesting master waits at most 3 other transactions.
- The pointer updates on every completion or abort, including aborts.
- Reset mid-BUSY: the transaction is dropped silently. No done/err is issued.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1.
  - NUM_REQ=4.
  - SEL_W=2.
  - reset value of the last pointer (2'd3).
- One natural sub-module: rr_pick4.
  - Combinational.
  - Inputs: req[3:0], last[1:0].
  - Outputs: any, winner[1:0].
- The controller FSM, counter and output registers stay in rr_bus_arbiter4.

Test Plan:
1. Single request:
   - Stimulus: reset; req=0001 at cycle 1; bus_ready pulse at cycle 4.
   - Response: cycle 2 grant=0001, sel=00, bus_valid=1, busy=1. Cycle 5 done=0001, grant=0000, bus_valid=0. Cycle 6 done=0000.
2. Round robin:
   - Stimulus: req=1111 held; bus_ready=1 on every BUSY cycle.
   - Response: grant sequence 0001, 0010, 0100, 1000, 0001, spaced 2 cycles apart. sel follows 0, 1, 2, 3, 0.
3. Timeout:
   - Stimulus: TIMEOUT=15; req=0100; bus_ready never asserted.
   - Response: bus_valid high for exactly 15 cycles, then err=0100 for one cycle, done=0000.
   - Re-grant of master 2 occurs in the err cycle, effective the next cycle, since it is the only requester.
4. Ready at the timeout boundary:
   - Stimulus: bus_ready=1 in the 15th BUSY cycle.
   - Response: done=0100, err=0000.
5. Reset mid-transaction:
   - Stimulus: reset_n low while BUSY with grant=0010, released asynchronously between edges; then req=1010.
   - Response: all outputs go to 0 immediately, with no done/err pulse. The first grant after release is 0010 (pointer=3, so master 1 wins over master 3).
6. Late request and pointer wrap:
   - Stimulus: req=1000 granted; req[0] rises while BUSY; bus_ready.
   - Response: the next grant is 0001 (pointer wraps 3→0). The req[0] rise does not disturb the current grant=1000 or sel=11.
